bit_serializer: RTL
===================

Name: bit_serializer

Overview:
- Upstream feeder for the serial sequence detector.
- Accepts parallel words over a valid/ready handshake and shifts them out one bit per clock on a single-bit line that drives the detector's data_in.
- Back-to-back words stream with no idle gap between them.
- When no word is in flight, the line idles at 0.

Parameters:
- WIDTH, 8: bits per input word; must be at least 2.
- MSB_FIRST, 1: 1 shifts the MSB out first; 0 shifts the LSB out first.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_data  input  WIDTH  parallel word to send.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a word this cycle.
- data_out  output  1  serial bit; connects to the detector's data_in.
- out_valid  output  1  data_out carries a real bit this cycle.
- busy  output  1  a frame is being shifted.
- word_done  output  1  one-cycle pulse coincident with the last bit of a frame.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port name reset.
- Reset: on any clk edge with reset=1, the block goes to IDLE with:
  - data_out=0, out_valid=0, busy=0, word_done=0
  - bit counter=0, shift register=0
  - in_ready=1 in the cycle after reset.
- Reset mid-frame: the in-flight word is discarded. Outputs are at their reset values from the next edge on. No partial word_done is issued.
- Registered outputs: data_out, out_valid, busy and word_done are registered. in_ready is combinational from state and counter, not from in_valid.
- FSM states:
  - IDLE: in_ready=1. On in_valid&&in_ready, load in_data, counter=0, go to SHIFT.
  - SHIFT: each cycle present one bit and increment the counter. in_ready=1 only when counter==FRAME-1 (last bit cycle).
    - At that edge, if in_valid=1: load the new word, counter=0, stay in SHIFT. The next word's first bit follows the previous last bit with zero gap.
    - At that edge, if in_valid=0: go to IDLE.
- Latency: the first bit appears on data_out one cycle after the accepting edge. A frame occupies FRAME consecutive out_valid cycles.
- FRAME = WIDTH (WIDTH+1 with parity; see Optional Feature).
- Bit order: MSB_FIRST=1 sends in_data[WIDTH-1] down to in_data[0]; MSB_FIRST=0 sends [0] up to [WIDTH-1].
- Counter: width $clog2(FRAME+1). It never exceeds FRAME-1; no wrap arithmetic is relied on.
- Outside frames: out_valid=0, data_out=0, busy=0.
- Data holding: in_data may change freely when in_ready=0. The block samples it only on an accepting edge.
- Simultaneous events: reset has priority over an accept on the same edge. An accept in the last-bit cycle takes priority over returning to IDLE.

Optional Feature:
- Macro: BIT_SERIALIZER_PARITY_EN.
- Defined: FRAME=WIDTH+1.
  - After the data bits, one even-parity bit is sent; it equals the XOR of the word's bits, so the total count of ones is even.
  - word_done and in_ready's last-cycle window move to the parity cycle.
- Undefined: FRAME=WIDTH, no parity logic is generated, and behaviour is exactly as above.

Decomposition:
- Package bit_serializer_pkg holds:
  - the state enum (IDLE, SHIFT)
  - the FRAME constant derivation (WIDTH, plus 1 under the macro)
  - the counter-width function.
- No sub-module. The shift register, counter and FSM stay in one module; the parity XOR is a single reduction.

Test Plan:
- Basic MSB-first:
  - Stimulus: WIDTH=8, MSB_FIRST=1, in_data=8'hB6 accepted at edge T.
  - Response: data_out=1,0,1,1,0,1,1,0 on cycles T+1..T+8; out_valid=1 throughout; word_done=1 only on T+8; then data_out=0, out_valid=0.
- Back-to-back:
  - Stimulus: 8'hFF then 8'h00, with in_valid held high.
  - Response: 16 contiguous out_valid cycles (eight 1s, eight 0s); in_ready=1 only on the 8th bit cycle; word_done pulses on bits 8 and 16.
- Hold-off:
  - Stimulus: in_valid=1 with 8'hA5 while busy on bit 3 of a frame.
  - Response: not accepted until the last-bit cycle; 8'hA5 bits start immediately after.
- Reset mid-frame:
  - Stimulus: reset=1 for one cycle after 3 bits of 8'hB6.
  - Response: next cycle data_out=0, out_valid=0, busy=0, in_ready=1; no word_done.
- LSB-first:
  - Stimulus: MSB_FIRST=0, in_data=8'h01.
  - Response: data_out=1 then seven 0s.
- Parity (macro defined):
  - Stimulus: 8'hB6.
  - Response: 9 bits, 1,0,1,1,0,1,1,0 followed by parity 1; word_done on the 9th bit.

Source files
------------

// File: rtl/bit_serializer_pkg.sv
// ============================================================================
// Module      : bit_serializer_pkg
// Description : Shared types and frame-length helpers for bit_serializer.
//               BIT_SERIALIZER_PARITY_EN adds one even-parity bit per frame.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bit_serializer_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  function automatic int frame_len(input int width);
`ifdef BIT_SERIALIZER_PARITY_EN
    return width + 1;
`else
    return width;
`endif
  endfunction

  function automatic int counter_width(input int frame);
    return $clog2(frame + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/bit_serializer.sv
// ============================================================================
// Module      : bit_serializer
// Description : Parallel-to-serial converter with valid/ready input, one bit
//               per clock, gapless back-to-back frames, line idles at 0.
//               Optional macro BIT_SERIALIZER_PARITY_EN appends even parity.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             data_out,
  output logic             out_valid,
  output logic             busy,
  output logic             word_done
);

  localparam int FRAME = frame_len(WIDTH);
  localparam int CW    = counter_width(FRAME);
  localparam logic [CW-1:0] C_LAST     = CW'(FRAME - 1);
  localparam logic [CW-1:0] C_PRE_LAST = CW'(FRAME - 2);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shreg;
  logic             next_bit;
  logic             accept;

  function automatic logic head(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  // cnt tracks the bit currently on data_out, so the last-bit window is cnt==FRAME-1
  assign in_ready = (state == IDLE) || (cnt == C_LAST);
  assign accept   = in_valid && in_ready;

`ifdef BIT_SERIALIZER_PARITY_EN
  logic parity;
  assign next_bit = (cnt == CW'(WIDTH - 1)) ? parity : head(shreg);
`else
  assign next_bit = head(shreg);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      shreg     <= '0;
      data_out  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      word_done <= 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
      parity    <= 1'b0;
`endif
    end else begin
      word_done <= 1'b0;
      if (accept) begin
        // first bit goes straight onto the line so a new frame abuts the previous one
        state     <= SHIFT;
        cnt       <= '0;
        shreg     <= advance(in_data);
        data_out  <= head(in_data);
        out_valid <= 1'b1;
        busy      <= 1'b1;
`ifdef BIT_SERIALIZER_PARITY_EN
        parity    <= ^in_data;
`endif
      end else if (state == SHIFT) begin
        if (cnt == C_LAST) begin
          state     <= IDLE;
          cnt       <= '0;
          shreg     <= '0;
          data_out  <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end else begin
          cnt       <= cnt + CW'(1);
          shreg     <= advance(shreg);
          data_out  <= next_bit;
          word_done <= (cnt == C_PRE_LAST);
        end
      end
    end
  end

endmodule

`default_nettype wire
